// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID/EX input latch set and EX/MEM output latch set of the execute stage
interface ex_stage_if;
    logic        HALTED;
    logic [31:0] ID_EX_A;
    logic [31:0] ID_EX_B;
    logic [31:0] ID_EX_IMM;
    logic [31:0] ID_EX_NPC;
    logic [31:0] ID_EX_IR;
    logic [2:0]  ID_EX_TYPE;
    logic        EX_Busy;
    logic [31:0] EX_MEM_ALUOut;
    logic [31:0] EX_MEM_B;
    logic [31:0] EX_MEM_IR;
    logic [2:0]  EX_MEM_TYPE;
    logic        EX_MEM_cond;
    logic [31:0] EX_BranchTarget;

    modport master (
        output HALTED, ID_EX_A, ID_EX_B, ID_EX_IMM, ID_EX_NPC, ID_EX_IR, ID_EX_TYPE,
        input  EX_Busy, EX_MEM_ALUOut, EX_MEM_B, EX_MEM_IR, EX_MEM_TYPE, EX_MEM_cond,
               EX_BranchTarget
    );

    modport slave (
        input  HALTED, ID_EX_A, ID_EX_B, ID_EX_IMM, ID_EX_NPC, ID_EX_IR, ID_EX_TYPE,
        output EX_Busy, EX_MEM_ALUOut, EX_MEM_B, EX_MEM_IR, EX_MEM_TYPE, EX_MEM_cond,
               EX_BranchTarget
    );
endinterface

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS32 execute stage: single-cycle ALU, iterative multiplier, branch squash
module ex_stage #(
    parameter int MUL_BITS     = 1,
    parameter int SQUASH_SLOTS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    ex_stage_if.slave  bus
);
    localparam int N  = 32 / MUL_BITS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = (SQUASH_SLOTS > 0) ? $clog2(SQUASH_SLOTS + 1) : 1;

    localparam logic [2:0] T_RR     = 3'b000;
    localparam logic [2:0] T_RM     = 3'b001;
    localparam logic [2:0] T_LOAD   = 3'b010;
    localparam logic [2:0] T_STORE  = 3'b011;
    localparam logic [2:0] T_BRANCH = 3'b100;
    localparam logic [2:0] T_HALT   = 3'b101;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nxt;
    logic [CW-1:0] cnt;
    logic [SW-1:0] sq_cnt;
    logic [31:0] mcand, mplier, acc, step, acc_nxt;
    logic [31:0] alu_q, b_q, ir_q, tgt_q;
    logic [2:0]  type_q;
    logic        cond_q;
    logic [5:0]  op;
    logic        live, mul_start, last, busy, take;
    logic [31:0] res;
    logic [31:0] w_alu, w_b, w_ir;
    logic [2:0]  w_type;
    logic        w_cond, w_tgt_en;

    assign op        = bus.ID_EX_IR[31:26];
    assign live      = (sq_cnt == '0);
    assign mul_start = live && (bus.ID_EX_TYPE == T_RR) && (op == OP_MUL);
    assign last      = (cnt == CW'(N - 1));

    // Multiplier FSM next state; busy holds decode until the final iteration
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (mul_start) begin
                    busy      = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                busy = !last;
                if (last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.EX_Busy = rst_n & busy;

    // Partial products of the next MUL_BITS multiplier bits
    always_comb begin
        step = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (mplier[i]) step = step + (mcand << i);
        end
        acc_nxt = acc + step;
    end

    // Single-cycle ALU result and branch decision
    always_comb begin
        res  = '0;
        take = 1'b0;
        case (bus.ID_EX_TYPE)
            T_RR: begin
                case (op)
                    OP_ADD:  res = bus.ID_EX_A + bus.ID_EX_B;
                    OP_SUB:  res = bus.ID_EX_A - bus.ID_EX_B;
                    OP_AND:  res = bus.ID_EX_A & bus.ID_EX_B;
                    OP_OR:   res = bus.ID_EX_A | bus.ID_EX_B;
                    OP_SLT:  res = {31'b0, $signed(bus.ID_EX_A) < $signed(bus.ID_EX_B)};
                    default: res = '0;
                endcase
            end
            T_RM: begin
                case (op)
                    OP_ADDI: res = bus.ID_EX_A + bus.ID_EX_IMM;
                    OP_SUBI: res = bus.ID_EX_A - bus.ID_EX_IMM;
                    OP_SLTI: res = {31'b0, $signed(bus.ID_EX_A) < $signed(bus.ID_EX_IMM)};
                    default: res = '0;
                endcase
            end
            T_LOAD, T_STORE: res = bus.ID_EX_A + bus.ID_EX_IMM;
            T_BRANCH: begin
                res  = bus.ID_EX_NPC + bus.ID_EX_IMM;
                take = ((op == OP_BEQZ) && (bus.ID_EX_A == '0)) ||
                       ((op == OP_BNEQZ) && (bus.ID_EX_A != '0));
            end
            default: res = '0;
        endcase
    end

    // Value written into EX_MEM this edge; bubble unless a result is ready
    always_comb begin
        w_alu    = '0;
        w_b      = '0;
        w_ir     = '0;
        w_type   = T_HALT;
        w_cond   = 1'b0;
        w_tgt_en = 1'b0;
        if (state == BUSY) begin
            if (last) begin
                w_alu  = acc_nxt;
                w_b    = bus.ID_EX_B;
                w_ir   = bus.ID_EX_IR;
                w_type = bus.ID_EX_TYPE;
            end
        end else if (live && !mul_start) begin
            w_alu    = res;
            w_b      = bus.ID_EX_B;
            w_ir     = bus.ID_EX_IR;
            w_type   = bus.ID_EX_TYPE;
            w_cond   = take;
            w_tgt_en = (bus.ID_EX_TYPE == T_BRANCH);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else if (!bus.HALTED) state <= state_nxt;
    end

    // EX_MEM latch, multiplier datapath and squash counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_q  <= '0;
            b_q    <= '0;
            ir_q   <= '0;
            type_q <= T_HALT;
            cond_q <= 1'b0;
            tgt_q  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            sq_cnt <= '0;
        end else if (!bus.HALTED) begin
            alu_q  <= w_alu;
            b_q    <= w_b;
            ir_q   <= w_ir;
            type_q <= w_type;
            cond_q <= w_cond;
            if (w_tgt_en) tgt_q <= res;
            if (state == BUSY) begin
                acc    <= acc_nxt;
                mcand  <= mcand << MUL_BITS;
                mplier <= mplier >> MUL_BITS;
                cnt    <= cnt + 1'b1;
            end else if (mul_start) begin
                mcand  <= bus.ID_EX_A;
                mplier <= bus.ID_EX_B;
                acc    <= '0;
                cnt    <= '0;
            end
            if ((state == IDLE) && !live) sq_cnt <= sq_cnt - 1'b1;
            else if (w_cond) sq_cnt <= SW'(SQUASH_SLOTS);
        end
    end

    assign bus.EX_MEM_ALUOut   = alu_q;
    assign bus.EX_MEM_B        = b_q;
    assign bus.EX_MEM_IR       = ir_q;
    assign bus.EX_MEM_TYPE     = type_q;
    assign bus.EX_MEM_cond     = cond_q;
    assign bus.EX_BranchTarget = tgt_q;
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage with an output-stream model
module tb_ex_stage;
    localparam int SQ = 2;
    localparam int N1 = 32;
    localparam logic [5:0] ADD = 6'd0, SUB = 6'd1, AND_ = 6'd2, OR_ = 6'd3, SLT = 6'd4,
                           MUL = 6'd5, LW = 6'd8, SW_ = 6'd9, ADDI = 6'd10, SUBI = 6'd11,
                           SLTI = 6'd12, BNEQZ = 6'd13, BEQZ = 6'd14, HLT = 6'd63;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] b;
        logic [31:0] ir;
        logic [2:0]  typ;
        logic        cond;
        logic [31:0] tgt;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst4_n;
    always #5 clk = ~clk;

    ex_stage_if bus();
    ex_stage_if bus4();

    ex_stage #(.MUL_BITS(1), .SQUASH_SLOTS(SQ)) dut  (.clk(clk), .rst_n(rst_n),  .bus(bus));
    ex_stage #(.MUL_BITS(4), .SQUASH_SLOTS(SQ)) dut4 (.clk(clk), .rst_n(rst4_n), .bus(bus4));

    int  total = 0;
    int  bad = 0;
    int  model_sq = 0;
    bit  cmp_en = 1'b0;
    wr_t q[$];
    wr_t e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [25:0] tag);
        return {op, tag};
    endfunction

    function automatic wr_t bubble();
        wr_t r;
        r.alu = 0; r.b = 0; r.ir = 0; r.typ = 3'b101; r.cond = 0; r.tgt = 0;
        return r;
    endfunction

    // What a live instruction must produce, straight from the opcode table
    function automatic wr_t expected(input logic [31:0] ir, input logic [2:0] typ,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] imm, input logic [31:0] npc);
        wr_t r;
        logic [5:0] op;
        op = ir[31:26];
        r.ir = ir; r.typ = typ; r.b = b; r.cond = 0; r.alu = 0; r.tgt = 0;
        if (typ == 3'd0) begin
            if (op == ADD) r.alu = a + b;
            else if (op == SUB) r.alu = a - b;
            else if (op == AND_) r.alu = a & b;
            else if (op == OR_) r.alu = a | b;
            else if (op == SLT) r.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            else if (op == MUL) r.alu = 32'(64'(a) * 64'(b));
        end else if (typ == 3'd1) begin
            if (op == ADDI) r.alu = a + imm;
            else if (op == SUBI) r.alu = a - imm;
            else if (op == SLTI) r.alu = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
        end else if (typ == 3'd2 || typ == 3'd3) begin
            r.alu = a + imm;
        end else if (typ == 3'd4) begin
            r.alu = npc + imm;
            r.tgt = npc + imm;
            r.cond = ((op == BEQZ) && (a == 0)) || ((op == BNEQZ) && (a != 0));
        end
        return r;
    endfunction

    task automatic model_push(input logic [31:0] ir, input logic [2:0] typ,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] imm, input logic [31:0] npc);
        wr_t r;
        if (model_sq > 0) begin
            q.push_back(bubble());
            model_sq--;
            return;
        end
        r = expected(ir, typ, a, b, imm, npc);
        if (typ == 3'd0 && ir[31:26] == MUL) begin
            for (int k = 0; k < N1; k++) q.push_back(bubble());
        end
        if (r.cond) model_sq = SQ;
        q.push_back(r);
    endtask

    // Every unhalted edge writes EX_MEM once; compare it with the model stream
    always begin
        @(posedge clk);
        if (cmp_en && rst_n && !bus.HALTED) begin
            @(negedge clk);
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL stream_empty actual=write expected=none");
            end else begin
                e = q.pop_front();
                chk("alu", bus.EX_MEM_ALUOut, e.alu);
                chk("b", bus.EX_MEM_B, e.b);
                chk("ir", bus.EX_MEM_IR, e.ir);
                chk("type", 32'(bus.EX_MEM_TYPE), 32'(e.typ));
                chk("cond", 32'(bus.EX_MEM_cond), 32'(e.cond));
                if (e.cond) chk("target", bus.EX_BranchTarget, e.tgt);
            end
        end
    end

    // Present one instruction and hold it while EX_Busy; optional 5-edge HALTED pulse
    task automatic issue(input logic [31:0] ir, input logic [2:0] typ,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] npc,
                         input int halt_at, output int edges, output int busy_cyc);
        bit bsy;
        bus.ID_EX_IR = ir; bus.ID_EX_TYPE = typ; bus.ID_EX_A = a; bus.ID_EX_B = b;
        bus.ID_EX_IMM = imm; bus.ID_EX_NPC = npc;
        model_push(ir, typ, a, b, imm, npc);
        edges = 0;
        busy_cyc = 0;
        do begin
            @(negedge clk);
            bsy = bus.EX_Busy;
            if (bsy) busy_cyc++;
            @(posedge clk);
            #1;
            edges++;
            if (halt_at >= 0 && edges == halt_at) bus.HALTED = 1'b1;
            if (halt_at >= 0 && edges == halt_at + 5) bus.HALTED = 1'b0;
        end while ((bsy || bus.HALTED) && edges < 300);
        if (edges >= 300) begin
            total++;
            bad++;
            $display("FAIL issue_timeout actual=%0d expected=<300", edges);
        end
    endtask

    task automatic nop_inputs();
        bus.HALTED = 0; bus.ID_EX_IR = 0; bus.ID_EX_TYPE = 3'b101;
        bus.ID_EX_A = 0; bus.ID_EX_B = 0; bus.ID_EX_IMM = 0; bus.ID_EX_NPC = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int ed, bc, nb, bc4;
        bit found;
        wr_t p;

        rst_n = 1'b0;
        rst4_n = 1'b0;
        nop_inputs();
        bus4.HALTED = 0; bus4.ID_EX_IR = 0; bus4.ID_EX_TYPE = 3'b101;
        bus4.ID_EX_A = 0; bus4.ID_EX_B = 0; bus4.ID_EX_IMM = 0; bus4.ID_EX_NPC = 0;

        // Model pins
        p = expected(mk(ADD, 0), 3'd0, 5, 7, 0, 0);                     chk("pin_add", p.alu, 32'd12);
        p = expected(mk(SLT, 0), 3'd0, 32'hFFFFFFFF, 1, 0, 0);          chk("pin_slt", p.alu, 32'd1);
        p = expected(mk(SLTI, 0), 3'd1, 3, 0, 32'hFFFFFFFE, 0);         chk("pin_slti", p.alu, 32'd0);
        p = expected(mk(SUBI, 0), 3'd1, 0, 0, 1, 0);                    chk("pin_subi", p.alu, 32'hFFFFFFFF);
        p = expected(mk(BEQZ, 0), 3'd4, 0, 0, 4, 32'h10);               chk("pin_beqz_tgt", p.tgt, 32'h14);
        chk("pin_beqz_cond", 32'(p.cond), 32'd1);
        p = expected(mk(MUL, 0), 3'd0, 7, 32'hFFFFFFFD, 0, 0);          chk("pin_mul", p.alu, 32'hFFFFFFEB);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_type", 32'(bus.EX_MEM_TYPE), 32'd5);
        chk("rst_ir", bus.EX_MEM_IR, 32'd0);
        chk("rst_alu", bus.EX_MEM_ALUOut, 32'd0);
        chk("rst_b", bus.EX_MEM_B, 32'd0);
        chk("rst_cond", 32'(bus.EX_MEM_cond), 32'd0);
        chk("rst_tgt", bus.EX_BranchTarget, 32'd0);
        chk("rst_busy", 32'(bus.EX_Busy), 32'd0);

        // MUL_BITS=4 instance: 8 busy cycles, 8 bubbles, then the product
        @(negedge clk) rst4_n = 1'b1;
        @(posedge clk); #1;
        bus4.ID_EX_IR = mk(MUL, 26'h44); bus4.ID_EX_TYPE = 3'd0;
        bus4.ID_EX_A = 7; bus4.ID_EX_B = 32'hFFFFFFFD;
        nb = 0; bc4 = 0; found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (bus4.EX_Busy) bc4++;
            @(posedge clk); #1;
            if (bus4.EX_MEM_TYPE == 3'd0 && bus4.EX_MEM_IR == mk(MUL, 26'h44)) found = 1;
            else if (bus4.EX_MEM_IR == 0 && bus4.EX_MEM_TYPE == 3'd5) nb++;
        end
        bus4.ID_EX_IR = 0; bus4.ID_EX_TYPE = 3'b101; bus4.ID_EX_A = 0; bus4.ID_EX_B = 0;
        chk("m4_found", 32'(found), 32'd1);
        chk("m4_busy_cycles", 32'(bc4), 32'd8);
        chk("m4_bubbles", 32'(nb), 32'd8);
        chk("m4_result", bus4.EX_MEM_ALUOut, 32'hFFFFFFEB);

        // Main instance, model-checked stream
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("pre_type", 32'(bus.EX_MEM_TYPE), 32'd5);
        chk("pre_ir", bus.EX_MEM_IR, 32'd0);
        cmp_en = 1'b1;

        issue(mk(ADD, 1), 3'd0, 5, 7, 0, 0, -1, ed, bc);
        chk("add_alu", bus.EX_MEM_ALUOut, 32'd12);
        chk("add_type", 32'(bus.EX_MEM_TYPE), 32'd0);
        issue(mk(SLT, 2), 3'd0, 32'hFFFFFFFF, 1, 0, 0, -1, ed, bc);
        chk("slt_alu", bus.EX_MEM_ALUOut, 32'd1);
        issue(mk(SLTI, 3), 3'd1, 3, 9, 32'hFFFFFFFE, 0, -1, ed, bc);
        chk("slti_alu", bus.EX_MEM_ALUOut, 32'd0);
        issue(mk(SUBI, 4), 3'd1, 0, 0, 1, 0, -1, ed, bc);
        chk("subi_alu", bus.EX_MEM_ALUOut, 32'hFFFFFFFF);
        issue(mk(SUB, 5), 3'd0, 3, 5, 0, 0, -1, ed, bc);
        issue(mk(AND_, 6), 3'd0, 32'hF0F0, 32'hFF00, 0, 0, -1, ed, bc);
        issue(mk(OR_, 7), 3'd0, 32'hF0F0, 32'h0F0F, 0, 0, -1, ed, bc);
        issue(mk(SLT, 8), 3'd0, 1, 32'hFFFFFFFF, 0, 0, -1, ed, bc);
        issue(mk(ADD, 9), 3'd0, 32'hFFFFFFFF, 1, 0, 0, -1, ed, bc);
        issue(mk(LW, 10), 3'd2, 100, 55, 8, 0, -1, ed, bc);
        issue(mk(SW_, 11), 3'd3, 200, 66, 32'hFFFFFFFC, 0, -1, ed, bc);
        chk("sw_b", bus.EX_MEM_B, 32'd66);
        issue(mk(ADDI, 12), 3'd1, 10, 0, 32'hFFFFFFFF, 0, -1, ed, bc);
        issue(mk(6'd7, 13), 3'd0, 4, 4, 0, 0, -1, ed, bc);

        // Taken BEQZ squashes two slots
        issue(mk(BEQZ, 20), 3'd4, 0, 0, 4, 32'h10, -1, ed, bc);
        chk("beqz_cond", 32'(bus.EX_MEM_cond), 32'd1);
        chk("beqz_tgt", bus.EX_BranchTarget, 32'h14);
        issue(mk(ADD, 21), 3'd0, 1, 1, 0, 0, -1, ed, bc);
        chk("sq1_type", 32'(bus.EX_MEM_TYPE), 32'd5);
        issue(mk(ADD, 22), 3'd0, 1, 1, 0, 0, -1, ed, bc);
        chk("sq2_ir", bus.EX_MEM_IR, 32'd0);
        issue(mk(ADD, 23), 3'd0, 1, 1, 0, 0, -1, ed, bc);
        chk("post_sq_alu", bus.EX_MEM_ALUOut, 32'd2);

        // Not-taken BNEQZ, no squash
        issue(mk(BNEQZ, 24), 3'd4, 0, 0, 4, 32'h20, -1, ed, bc);
        chk("bneqz_cond", 32'(bus.EX_MEM_cond), 32'd0);
        issue(mk(ADD, 25), 3'd0, 2, 2, 0, 0, -1, ed, bc);
        chk("no_sq_alu", bus.EX_MEM_ALUOut, 32'd4);

        // A squashed branch must not set cond nor reload the squash count
        issue(mk(BEQZ, 26), 3'd4, 0, 0, 8, 32'h30, -1, ed, bc);
        issue(mk(BEQZ, 27), 3'd4, 0, 0, 8, 32'h40, -1, ed, bc);
        chk("sq_br_cond", 32'(bus.EX_MEM_cond), 32'd0);
        issue(mk(ADD, 28), 3'd0, 1, 2, 0, 0, -1, ed, bc);
        issue(mk(ADD, 29), 3'd0, 3, 3, 0, 0, -1, ed, bc);
        chk("sq_br_after", bus.EX_MEM_ALUOut, 32'd6);

        // Taken BNEQZ squashes a MUL, which must not go busy
        issue(mk(BNEQZ, 30), 3'd4, 5, 0, 32'hFFFFFFF0, 32'h20, -1, ed, bc);
        chk("bneqz_tgt", bus.EX_BranchTarget, 32'h10);
        issue(mk(MUL, 31), 3'd0, 7, 9, 0, 0, -1, ed, bc);
        chk("sq_mul_edges", 32'(ed), 32'd1);
        chk("sq_mul_busy", 32'(bc), 32'd0);
        issue(mk(ADD, 32), 3'd0, 1, 1, 0, 0, -1, ed, bc);
        issue(mk(ADD, 33), 3'd0, 3, 4, 0, 0, -1, ed, bc);
        chk("sq_mul_after", bus.EX_MEM_ALUOut, 32'd7);

        issue(mk(HLT, 34), 3'd5, 9, 9, 9, 9, -1, ed, bc);
        chk("hlt_ir", bus.EX_MEM_IR, mk(HLT, 34));

        // MUL_BITS=1: 32 busy cycles, result on edge 33
        issue(mk(MUL, 40), 3'd0, 7, 32'hFFFFFFFD, 0, 0, -1, ed, bc);
        chk("mul_edges", 32'(ed), 32'd33);
        chk("mul_busy", 32'(bc), 32'd32);
        chk("mul_alu", bus.EX_MEM_ALUOut, 32'hFFFFFFEB);
        issue(mk(MUL, 41), 3'd0, 32'h12345, 32'h6789, 0, 0, -1, ed, bc);

        // HALTED for 5 edges mid-BUSY delays the result by exactly 5
        issue(mk(MUL, 42), 3'd0, 7, 32'hFFFFFFFD, 0, 0, 10, ed, bc);
        chk("mul_halt_edges", 32'(ed), 32'd38);
        chk("mul_halt_alu", bus.EX_MEM_ALUOut, 32'hFFFFFFEB);

        // Reset in the middle of a multiply
        cmp_en = 1'b0;
        bus.ID_EX_IR = mk(MUL, 43); bus.ID_EX_TYPE = 3'd0; bus.ID_EX_A = 3; bus.ID_EX_B = 5;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mrst_type", 32'(bus.EX_MEM_TYPE), 32'd5);
        chk("mrst_ir", bus.EX_MEM_IR, 32'd0);
        chk("mrst_alu", bus.EX_MEM_ALUOut, 32'd0);
        chk("mrst_tgt", bus.EX_BranchTarget, 32'd0);
        chk("mrst_busy", 32'(bus.EX_Busy), 32'd0);
        nop_inputs();
        q.delete();
        model_sq = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        cmp_en = 1'b1;
        issue(mk(ADD, 44), 3'd0, 1, 2, 0, 0, -1, ed, bc);
        chk("mrst_add", bus.EX_MEM_ALUOut, 32'd3);
        cmp_en = 1'b0;
        nop_inputs();
        repeat (2) @(negedge clk);
        chk("stream_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS32 pipeline; consumes the ID_EX_* latch set produced by decode and produces the EX_MEM_* latch set.
- Single-cycle ALU for RR/RM/LOAD/STORE/BRANCH; MUL is iterative (shift-add) and back-pressures decode via EX_Busy.
- Resolves branches, drives the taken target to fetch, and squashes wrong-path slots arriving behind a taken branch.

Parameters:
- MUL_BITS, 1, multiplier bits retired per iteration; legal 1, 2, 4; N = 32/MUL_BITS iterations.
- SQUASH_SLOTS, 2, number of incoming instructions converted to bubbles after a taken branch.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  reset, asynchronous, active-low.
- HALTED  in  1  when 1, all state and outputs hold.
- ID_EX_A  in  32  rs operand.
- ID_EX_B  in  32  rt operand.
- ID_EX_IMM  in  32  sign-extended immediate.
- ID_EX_NPC  in  32  PC+1 of the instruction.
- ID_EX_IR  in  32  instruction; opcode in [31:26].
- ID_EX_TYPE  in  3  RR=000, RM=001, LOAD=010, STORE=011, BRANCH=100, HALT=101.
- EX_Busy  out  1  combinational; decode and fetch hold ID_EX_*/IF_ID_* while 1.
- EX_MEM_ALUOut  out  32  result or effective address.
- EX_MEM_B  out  32  store data (ID_EX_B passthrough).
- EX_MEM_IR  out  32  instruction, 0 for a bubble.
- EX_MEM_TYPE  out  3  type, HALT for a bubble.
- EX_MEM_cond  out  1  branch taken, registered.
- EX_BranchTarget  out  32  ID_EX_NPC + ID_EX_IMM, registered with EX_MEM_cond.

Behaviour:
- Reset (async, rst_n=0): all EX_MEM_* = 0 except EX_MEM_TYPE=101; EX_MEM_cond=0, EX_BranchTarget=0; FSM=IDLE; iteration counter=0; squash counter=0. EX_Busy=0.
- Bubble: EX_MEM_IR=0, EX_MEM_TYPE=101, ALUOut=0, B=0, cond=0. Downstream recognises a true halt by EX_MEM_IR[31:26]=111111.
- Incoming instruction is "live" when squash counter = 0; otherwise a bubble is written, and the counter decrements.
- Opcodes: ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101, HLT 111111, LW 001000, SW 001001, ADDI 001010, SUBI 001011, SLTI 001100, BNEQZ 001101, BEQZ 001110.
- Single-cycle ops (one edge latency, IDLE only): RR: A op B; SLT signed, result 0/1. RM: ADDI A+IMM, SUBI A-IMM, SLTI signed A<IMM. LOAD/STORE: ALUOut=A+IMM, B passed. All arithmetic modulo 2^32, no overflow flag. HALT type: IR/TYPE passed, ALUOut=0. Unknown opcodes pass through as TYPE given.
- BRANCH: EX_MEM_cond = (BEQZ & A==0) | (BNEQZ & A!=0); EX_BranchTarget = NPC+IMM; ALUOut = NPC+IMM. If taken, squash counter loads SQUASH_SLOTS at the same edge. Non-live branch never sets cond. cond is 0 on every non-branch write.
- MUL FSM: IDLE, BUSY.
  - IDLE + live MUL: latch A (multiplicand), B (multiplier), clear accumulator and counter, write bubble, go to BUSY. EX_Busy=1 this cycle.
  - BUSY: each edge adds the partial products of MUL_BITS multiplier bits and advances the counter. EX_Busy=1 while counter < N-1.
  - On the final iteration (counter = N-1), EX_Busy=0 and EX_MEM gets ALUOut=low 32 bits of A*B with the MUL IR/TYPE. The FSM returns to IDLE.
  - Result appears N+1 edges after MUL enters, preceded by N bubbles.
- HALTED=1: no register changes, including the FSM, counters, and squash. EX_Busy holds its value.
- rst_n low mid-multiply: immediate abort to IDLE; no result is written.
- Squash has priority over MUL start: a squashed MUL never enters BUSY.

Test Plan:
- Reset release, then ADD with A=5, B=7 -> next edge EX_MEM_ALUOut=12, TYPE=000, cond=0; before that, EX_MEM_TYPE=101 and IR=0.
- SLT with A=0xFFFFFFFF, B=1 -> ALUOut=1; SLTI with A=3, IMM=-2 -> ALUOut=0; SUBI with A=0, IMM=1 -> 0xFFFFFFFF.
- BEQZ with A=0, NPC=0x10, IMM=4 -> cond=1, target=0x14. The next two ADDs come out as bubbles and the third ADD executes. BNEQZ with A=0 -> cond=0 and no squash.
- MUL with A=7, B=0xFFFFFFFD and MUL_BITS=1 -> EX_Busy high for 32 cycles, 32 bubbles, then ALUOut=0xFFFFFFEB. Repeat with MUL_BITS=4: 8 bubbles, same result.
- MUL with HALTED pulsed for 5 cycles mid-BUSY -> result delayed by exactly 5 cycles and its value is unchanged.
- rst_n asserted during BUSY -> outputs return to reset values immediately and EX_Busy=0. After release, an ADD executes normally.
